simplez_cpu: RTL

SIMPLEZ_CPU -- requirements
Module: simplez_cpu

---
 rtl/simplez_pkg.sv | 36 +++
 rtl/simplez_seq.sv | 79 +++++++
 rtl/simplez_cpu.sv | 79 +++++++
 3 files changed

// File: rtl/simplez_pkg.sv
// Shared opcode, FSM-state and control-word definitions for the Simplez CPU.
package simplez_pkg;

  typedef enum logic [2:0] {
    OP_ST   = 3'd0,
    OP_LD   = 3'd1,
    OP_ADD  = 3'd2,
    OP_BR   = 3'd3,
    OP_BZ   = 3'd4,
    OP_CLR  = 3'd5,
    OP_DEC  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_OPER,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic addr_cd;
    logic ri_load;
    logic pc_inc;
    logic pc_load;
    logic ac_clr;
    logic ac_dec;
    logic ac_ld;
    logic ac_add;
  } ctrl_t;

endpackage

// File: rtl/simplez_seq.sv
// Simplez sequencer: five-state FSM plus decode of memory strobes and datapath enables.
module simplez_seq
  import simplez_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    run,
  input  opcode_t op,
  input  logic    ac_zero,
  output ctrl_t   ctrl,
  output logic    stop
);

  state_t state, next_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (run) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LD, OP_ADD: next_state = S_OPER;
          OP_HALT:       next_state = S_HALTED;
          default:       next_state = S_FETCH;
        endcase
      end
      S_OPER:   next_state = S_FETCH;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    stop = 1'b0;
    case (state)
      S_FETCH:  ctrl.rd = run;
      S_DECODE: begin
        ctrl.ri_load = 1'b1;
        ctrl.pc_inc  = 1'b1;
      end
      S_EXEC: begin
        case (op)
          OP_ST: begin
            ctrl.wr      = 1'b1;
            ctrl.addr_cd = 1'b1;
          end
          OP_LD, OP_ADD: begin
            ctrl.rd      = 1'b1;
            ctrl.addr_cd = 1'b1;
          end
          OP_BR:   ctrl.pc_load = 1'b1;
          OP_BZ:   ctrl.pc_load = ac_zero;
          OP_CLR:  ctrl.ac_clr  = 1'b1;
          OP_DEC:  ctrl.ac_dec  = 1'b1;
          default: ;
        endcase
      end
      S_OPER: begin
        ctrl.ac_ld  = (op == OP_LD);
        ctrl.ac_add = (op == OP_ADD);
      end
      S_HALTED: stop = 1'b1;
      default: ;
    endcase
    // Strobes are gated by rstn itself so they drop the instant reset asserts.
    if (!rstn) begin
      ctrl.rd = 1'b0;
      ctrl.wr = 1'b0;
    end
  end

endmodule

// File: rtl/simplez_cpu.sv
// Simplez accumulator CPU: PC, AC and RI datapath around the simplez_seq controller.
module simplez_cpu
  import simplez_pkg::*;
#(
  parameter int          DATAW    = 12,
  parameter int          ADDRW    = 9,
  parameter int unsigned RESET_PC = 0,
  parameter int          LEDW     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata,
  output logic [ADDRW-1:0] pc,
  output logic [DATAW-1:0] ac,
  output logic [LEDW-1:0]  leds,
  output logic             stop
);

  localparam logic [ADDRW-1:0] PC0 = ADDRW'(RESET_PC);

  if (DATAW < ADDRW + 3) begin : g_bad_dataw
    $error("simplez_cpu: DATAW must be at least ADDRW+3");
  end
  if (LEDW > DATAW) begin : g_bad_ledw
    $error("simplez_cpu: LEDW must not exceed DATAW");
  end

  // Only the CO and CD fields of RI are kept; the bits between them are never used.
  logic [2:0]       ri_co;
  logic [ADDRW-1:0] ri_cd;
  ctrl_t            ctrl;

  simplez_seq u_seq (
    .clk     (clk),
    .rstn    (rstn),
    .run     (run),
    .op      (opcode_t'(ri_co)),
    .ac_zero (ac == '0),
    .ctrl    (ctrl),
    .stop    (stop)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc    <= PC0;
      ac    <= '0;
      ri_co <= '0;
      ri_cd <= '0;
    end else begin
      if (ctrl.ri_load) begin
        ri_co <= mem_rdata[DATAW-1 -: 3];
        ri_cd <= mem_rdata[ADDRW-1:0];
      end
      if (ctrl.pc_inc)       pc <= pc + ADDRW'(1);
      else if (ctrl.pc_load) pc <= ri_cd;
      if (ctrl.ac_clr)       ac <= '0;
      else if (ctrl.ac_dec)  ac <= ac - DATAW'(1);
      else if (ctrl.ac_ld)   ac <= mem_rdata;
      else if (ctrl.ac_add)  ac <= ac + mem_rdata;
    end
  end

  always_comb begin
    if (!rstn)             mem_addr = '0;
    else if (ctrl.addr_cd) mem_addr = ri_cd;
    else                   mem_addr = pc;
  end

  assign mem_rd    = ctrl.rd;
  assign mem_wr    = ctrl.wr;
  assign mem_wdata = ctrl.wr ? ac : '0;
  assign leds      = ac[LEDW-1:0];

endmodule
